hilo_muldiv_unit: RTL and testbench

- Execute-stage consumer of the decoder's DIV, MULT, MFHL and MTHL fields.
- Owns the architectural HI/LO registers.
- Runs div/divu as an iterative 32-step restoring divider and, optionally, mult/multu as a short pipelined multiply.
- Stalls the pipeline via busy and serves mfhi/mflo reads.

---
 rtl/cpu_defs_pkg.sv | 34 +++
 rtl/hilo_muldiv_unit_if.sv | 35 +++
 rtl/div_core.sv | 72 +++++++
 rtl/hilo_muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// ----------------------------------------------------------------------------
// cpu_defs_pkg : decode field bit positions, HI/LO FSM encoding, divider sizing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_defs_pkg;

   localparam int DIV_S_BIT   = 0;
   localparam int DIV_U_BIT   = 1;
   localparam int MULT_S_BIT  = 0;
   localparam int MULT_U_BIT  = 1;
   localparam int MTHL_LO_BIT = 0;
   localparam int MTHL_HI_BIT = 1;
   localparam int MFHL_LO_BIT = 0;
   localparam int MFHL_HI_BIT = 1;

   localparam int DIV_ITERS = 32;
   localparam int DIV_CNT_W = $clog2(DIV_ITERS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DIV_RUN = 2'd1,
`ifdef MULDIV_MULT_EN
      ST_DIV_FIX = 2'd2,
      ST_MUL_RUN = 2'd3
`else
      ST_DIV_FIX = 2'd2
`endif
   } state_e;

endpackage

`default_nettype wire

// File: rtl/hilo_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_unit_if : EX-stage request/response bundle of the HI/LO unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hilo_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            issue;
   logic            cancel;
   logic [1:0]      DIV;
   logic [1:0]      MULT;
   logic [1:0]      MTHL;
   logic [1:0]      MFHL;
   logic [XLEN-1:0] rs_data;
   logic [XLEN-1:0] rt_data;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hilo_rdata;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output issue, cancel, DIV, MULT, MTHL, MFHL, rs_data, rt_data,
      input  busy, done, hilo_rdata, hi, lo
   );

   modport slave (
      input  issue, cancel, DIV, MULT, MTHL, MFHL, rs_data, rt_data,
      output busy, done, hilo_rdata, hi, lo
   );
endinterface

`default_nettype wire

// File: rtl/div_core.sv
// ----------------------------------------------------------------------------
// div_core : unsigned iterative restoring divider, one quotient bit per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_core
   import cpu_defs_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start_i,
   input  logic         cancel_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic         last_o,
   output logic [W-1:0] quotient_o,
   output logic [W-1:0] remainder_o
);

   logic                 run_q;
   logic [DIV_CNT_W-1:0] count_q;
   logic [2*W-1:0]       rem_q;
   logic [2*W-1:0]       rem_d;
   logic [W-1:0]         divisor_q;
   logic [2*W:0]         shifted;
   logic [W-1:0]         diff;
   logic                 fits;

   // Upper half holds the partial remainder, lower half shifts dividend out / quotient in.
   always_comb begin
      shifted = {rem_q, 1'b0};
      fits    = shifted[2*W:W] >= {1'b0, divisor_q};
      diff    = shifted[2*W-1:W] - divisor_q;
      rem_d   = shifted[2*W-1:0];
      if (fits) begin
         rem_d = {diff, shifted[W-1:1], 1'b1};
      end
   end

   assign last_o      = run_q && (count_q == DIV_CNT_W'(DIV_ITERS - 1));
   assign quotient_o  = rem_q[W-1:0];
   assign remainder_o = rem_q[2*W-1:W];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         run_q     <= 1'b0;
         count_q   <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
      end else if (cancel_i) begin
         run_q   <= 1'b0;
         count_q <= '0;
      end else if (start_i) begin
         run_q     <= 1'b1;
         count_q   <= '0;
         rem_q     <= {{W{1'b0}}, dividend_i};
         divisor_q <= divisor_i;
      end else if (run_q) begin
         rem_q   <= rem_d;
         count_q <= count_q + 1'b1;
         if (last_o) begin
            run_q <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_unit : HI/LO owner, div/divu sequencer, mthi/mtlo and mfhi/mflo;
// optional pipelined mult/multu enabled by macro MULDIV_MULT_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hilo_muldiv_unit
   import cpu_defs_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2
) (
   input  logic               clk,
   input  logic               resetn,
   hilo_muldiv_unit_if.slave  bus
);

   if (XLEN != 32 || MUL_LAT < 1 || MUL_LAT > 3) begin : g_bad_cfg
      $error("hilo_muldiv_unit: unsupported XLEN or MUL_LAT");
   end

   state_e          state_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic            done_q;
   logic            q_neg_q;
   logic            r_neg_q;

   logic            idle_req;
   logic            div_req;
   logic            mul_req;
   logic            div_signed;
   logic [XLEN-1:0] rs_abs;
   logic [XLEN-1:0] rt_abs;
   logic            div_last;
   logic [XLEN-1:0] quot;
   logic [XLEN-1:0] rem;

   assign idle_req   = bus.issue && !bus.cancel && (state_q == ST_IDLE);
   assign div_req    = idle_req && (|bus.DIV);
   assign div_signed = bus.DIV[DIV_S_BIT];
   assign rs_abs     = (div_signed && bus.rs_data[XLEN-1]) ? -bus.rs_data : bus.rs_data;
   assign rt_abs     = (div_signed && bus.rt_data[XLEN-1]) ? -bus.rt_data : bus.rt_data;

`ifdef MULDIV_MULT_EN
   logic [2*XLEN-1:0] mul_a;
   logic [2*XLEN-1:0] mul_b;
   logic [2*XLEN-1:0] mul_prod;
   logic [2*XLEN-1:0] mul_pipe_q [MUL_LAT];
   logic [1:0]        mul_cnt_q;

   assign mul_req  = idle_req && (|bus.MULT) && !(|bus.DIV);
   assign mul_a    = {{XLEN{bus.MULT[MULT_S_BIT] & bus.rs_data[XLEN-1]}}, bus.rs_data};
   assign mul_b    = {{XLEN{bus.MULT[MULT_S_BIT] & bus.rt_data[XLEN-1]}}, bus.rt_data};
   assign mul_prod = mul_a * mul_b;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < MUL_LAT; k++) mul_pipe_q[k] <= '0;
      end else begin
         if (mul_req) mul_pipe_q[0] <= mul_prod;
         for (int k = 1; k < MUL_LAT; k++) mul_pipe_q[k] <= mul_pipe_q[k-1];
      end
   end
`else
   assign mul_req = 1'b0;
`endif

   div_core #(.W(XLEN)) u_div_core (
      .clk         (clk),
      .resetn      (resetn),
      .start_i     (div_req),
      .cancel_i    (bus.cancel),
      .dividend_i  (rs_abs),
      .divisor_i   (rt_abs),
      .last_o      (div_last),
      .quotient_o  (quot),
      .remainder_o (rem)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
`ifdef MULDIV_MULT_EN
         mul_cnt_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         // A flush outranks everything, including the final HI/LO write.
         if (bus.cancel) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (div_req) begin
                     q_neg_q <= div_signed && (bus.rs_data[XLEN-1] ^ bus.rt_data[XLEN-1]);
                     r_neg_q <= div_signed && bus.rs_data[XLEN-1];
                     state_q <= ST_DIV_RUN;
`ifdef MULDIV_MULT_EN
                  end else if (mul_req) begin
                     mul_cnt_q <= '0;
                     state_q   <= ST_MUL_RUN;
`endif
                  end else if (bus.issue) begin
                     if (bus.MTHL[MTHL_HI_BIT]) hi_q <= bus.rs_data;
                     if (bus.MTHL[MTHL_LO_BIT]) lo_q <= bus.rs_data;
                  end
               end
               ST_DIV_RUN: begin
                  if (div_last) state_q <= ST_DIV_FIX;
               end
               ST_DIV_FIX: begin
                  lo_q    <= q_neg_q ? -quot : quot;
                  hi_q    <= r_neg_q ? -rem : rem;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
`ifdef MULDIV_MULT_EN
               ST_MUL_RUN: begin
                  mul_cnt_q <= mul_cnt_q + 1'b1;
                  if (mul_cnt_q == 2'(MUL_LAT - 1)) begin
                     {hi_q, lo_q} <= mul_pipe_q[MUL_LAT-1];
                     done_q       <= 1'b1;
                     state_q      <= ST_IDLE;
                  end
               end
`endif
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.busy       = (state_q != ST_IDLE) || div_req || mul_req;
   assign bus.done       = done_q;
   assign bus.hi         = hi_q;
   assign bus.lo         = lo_q;
   assign bus.hilo_rdata = bus.MFHL[MFHL_HI_BIT] ? hi_q :
                           bus.MFHL[MFHL_LO_BIT] ? lo_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_hilo_muldiv_unit : directed scoreboard bench for hilo_muldiv_unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hilo_muldiv_unit;

   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   hilo_muldiv_unit_if #(.XLEN(32)) bus ();

   hilo_muldiv_unit #(.XLEN(32), .MUL_LAT(2)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      string       tag;
      logic [63:0] hilo;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_hi = 32'h0;
   logic [31:0] m_lo = 32'h0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.issue   = 1'b0;
      bus.cancel  = 1'b0;
      bus.DIV     = 2'b00;
      bus.MULT    = 2'b00;
      bus.MTHL    = 2'b00;
      bus.MFHL    = 2'b00;
      bus.rs_data = 32'h0;
      bus.rt_data = 32'h0;
   endtask

   // Issue one div/mult, count busy cycles from the accept cycle, score HI/LO at done.
   task automatic run_op(input string tag, input logic [1:0] div, input logic [1:0] mult,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_hilo, input int exp_busy);
      int   cyc;
      bit   got;
      exp_t e;
      @(negedge clk);
      bus.issue   = 1'b1;
      bus.DIV     = div;
      bus.MULT    = mult;
      bus.rs_data = a;
      bus.rt_data = b;
      sb.push_back('{tag, exp_hilo});
      #1;
      check({tag, "/busy_accept"}, 64'(bus.busy), 64'd1);
      cyc = bus.busy ? 1 : 0;
      @(negedge clk);
      idle_inputs();
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (bus.done) got = 1'b1;
         else begin
            if (bus.busy) cyc++;
            @(negedge clk);
         end
      end
      check({tag, "/done_seen"}, 64'(got), 64'd1);
      check({tag, "/busy_cycles"}, 64'(cyc), 64'(exp_busy));
      e = sb.pop_front();
      if (got) begin
         check({e.tag, "/hilo"}, {bus.hi, bus.lo}, e.hilo);
         check({tag, "/busy_at_done"}, 64'(bus.busy), 64'd0);
         @(negedge clk);
         check({tag, "/done_width"}, 64'(bus.done), 64'd0);
      end
      m_hi = exp_hilo[63:32];
      m_lo = exp_hilo[31:0];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int dones;
      idle_inputs();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      @(negedge clk);
      bus.MFHL = 2'b11;
      #1;
      check("reset/hilo", {bus.hi, bus.lo}, 64'h0);
      check("reset/busy", 64'(bus.busy), 64'd0);
      check("reset/done", 64'(bus.done), 64'd0);
      check("reset/rdata", 64'(bus.hilo_rdata), 64'h0);
      bus.MFHL = 2'b00;

      run_op("div_m7_2",     2'b01, 2'b00, 32'hFFFFFFF9, 32'h2,        64'hFFFFFFFF_FFFFFFFD, 34);
      run_op("divu_big_2",   2'b10, 2'b00, 32'hFFFFFFF9, 32'h2,        64'h00000001_7FFFFFFC, 34);
      run_op("divu_by_zero", 2'b10, 2'b00, 32'hFFFFFFF9, 32'h0,        64'hFFFFFFF9_FFFFFFFF, 34);
      run_op("div_overflow", 2'b01, 2'b00, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
      run_op("div_7_m2",     2'b01, 2'b00, 32'h7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
      run_op("div_100_7",    2'b01, 2'b00, 32'd100,      32'd7,        64'h00000002_0000000E, 34);

      @(negedge clk);
      bus.MFHL = 2'b10;
      #1;
      check("mfhi_after_div", 64'(bus.hilo_rdata), 64'(m_hi));
      bus.MFHL = 2'b01;
      #1;
      check("mflo_after_div", 64'(bus.hilo_rdata), 64'(m_lo));

      // mtlo 0, then mthi with an mflo in the same cycle
      @(negedge clk);
      idle_inputs();
      bus.issue = 1'b1;
      bus.MTHL  = 2'b01;
      #1;
      check("mtlo/busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      bus.MTHL    = 2'b10;
      bus.rs_data = 32'h12345678;
      bus.MFHL    = 2'b01;
      #1;
      check("mthi/mflo_rdata", 64'(bus.hilo_rdata), 64'h0);
      @(negedge clk);
      idle_inputs();
      bus.MFHL = 2'b10;
      #1;
      check("mthi/hi", 64'(bus.hi), 64'h12345678);
      check("mthi/mfhi_rdata", 64'(bus.hilo_rdata), 64'h12345678);
      bus.MFHL = 2'b01;
      #1;
      check("mthi/mflo_rdata2", 64'(bus.hilo_rdata), 64'h0);
      bus.MFHL = 2'b00;
      #1;
      check("mfhl_none_rdata", 64'(bus.hilo_rdata), 64'h0);
      m_hi = 32'h12345678;
      m_lo = 32'h0;

      // cancel a divide at its tenth cycle
      @(negedge clk);
      bus.issue   = 1'b1;
      bus.DIV     = 2'b01;
      bus.rs_data = 32'd100;
      bus.rt_data = 32'd7;
      @(negedge clk);
      idle_inputs();
      dones = 0;
      for (int i = 1; i < 10; i++) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      check("cancel/busy_before", 64'(bus.busy), 64'd1);
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      #1;
      check("cancel/busy_after", 64'(bus.busy), 64'd0);
      check("cancel/hilo_kept", {bus.hi, bus.lo}, {m_hi, m_lo});
      for (int i = 0; i < 40; i++) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      check("cancel/no_done", 64'(dones), 64'd0);
      check("cancel/hilo_still", {bus.hi, bus.lo}, {m_hi, m_lo});

      run_op("div_after_cancel", 2'b01, 2'b00, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 34);

`ifdef MULDIV_MULT_EN
      run_op("mult_m1_3",  2'b00, 2'b01, 32'hFFFFFFFF, 32'd3, 64'hFFFFFFFF_FFFFFFFD, 3);
      run_op("multu_m1_3", 2'b00, 2'b10, 32'hFFFFFFFF, 32'd3, 64'h00000002_FFFFFFFD, 3);
`else
      @(negedge clk);
      bus.issue   = 1'b1;
      bus.MULT    = 2'b01;
      bus.rs_data = 32'hFFFFFFFF;
      bus.rt_data = 32'd3;
      #1;
      check("mult_off/busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      idle_inputs();
      check("mult_off/hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
      check("mult_off/done", 64'(bus.done), 64'd0);
`endif

      // reset in the middle of a divide
      @(negedge clk);
      bus.issue   = 1'b1;
      bus.DIV     = 2'b10;
      bus.rs_data = 32'd1000;
      bus.rt_data = 32'd3;
      @(negedge clk);
      idle_inputs();
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check("midreset/busy", 64'(bus.busy), 64'd0);
      check("midreset/hilo", {bus.hi, bus.lo}, 64'h0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      check("midreset/no_done", 64'(dones), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
